// File: rtl/cdr_dlf_pkg.sv
// Shared types, decision encodings and the saturating adder for the CDR loop filter.
package cdr_dlf_pkg;

  // Decimated phase-detector decision: +1 late, -1 early, 0 no majority.
  typedef logic signed [1:0] dec_t;

  localparam dec_t DEC_UP   = 2'sb01;
  localparam dec_t DEC_DN   = 2'sb11;
  localparam dec_t DEC_NONE = 2'sb00;

  // Adds delta to freq and clamps the result to the symmetric range
  // [-(2^(width-1)-1), +(2^(width-1)-1)], so the most negative code never appears.
  function automatic longint sat_add(input longint freq, input longint delta,
                                     input int width = 16);
    longint max_v;
    longint sum_v;
    longint res_v;
    max_v = (longint'(1) <<< (width - 1)) - longint'(1);
    sum_v = freq + delta;
    res_v = sum_v;
    if (sum_v > max_v) begin
      res_v = max_v;
    end else if (sum_v < -max_v) begin
      res_v = -max_v;
    end
    return res_v;
  endfunction

endpackage

// File: rtl/cdr_dlf_prog_if.sv
// Bundle of phase-detector inputs, gain/freeze controls and interpolator outputs.
interface cdr_dlf_prog_if #(
  parameter int CODE_W = 11,
  parameter int FREQ_W = 16
);

  logic                     up;
  logic                     dn;
  logic [2:0]               kp;
  logic [2:0]               ki;
  logic                     freeze;
  logic [CODE_W-1:0]        code;
  logic                     code_valid;
  logic signed [FREQ_W-1:0] freq;
  logic                     freq_sat;

  // The master drives votes and controls; the loop filter answers with the code.
  modport master (
    output up, dn, kp, ki, freeze,
    input  code, code_valid, freq, freq_sat
  );

  modport slave (
    input  up, dn, kp, ki, freeze,
    output code, code_valid, freq, freq_sat
  );

endinterface

// File: rtl/dlf_vote_decimator.sv
// Accumulates bang-bang votes over a DECIM-cycle window and emits a signed decision.
module dlf_vote_decimator
  import cdr_dlf_pkg::*;
#(
  parameter int DECIM = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic up,
  input  logic dn,
  output dec_t dec_q,
  output logic upd_q
);

  localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int SUM_W = $clog2(DECIM + 1) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [SUM_W-1:0] sum_q, sum_d;
  logic signed [SUM_W-1:0] vote;
  logic signed [SUM_W-1:0] total;
  dec_t                    dec_d;
  logic                    upd_d;

  // Vote, accumulate, and on the last window cycle turn the sum into a sign decision.
  always_comb begin
    vote = '0;
    if (up && !dn) begin
      vote = {{(SUM_W-1){1'b0}}, 1'b1};
    end else if (dn && !up) begin
      vote = '1;
    end
    total = sum_q + vote;

    cnt_d = cnt_q + 1'b1;
    sum_d = total;
    dec_d = dec_q;
    upd_d = 1'b0;

    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      sum_d = '0;
      upd_d = 1'b1;
      if (total[SUM_W-1]) begin
        dec_d = DEC_DN;
      end else if (total != '0) begin
        dec_d = DEC_UP;
      end else begin
        dec_d = DEC_NONE;
      end
    end
  end

  // Window state; reset discards any partial sum so the next window is full length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sum_q <= '0;
      dec_q <= DEC_NONE;
      upd_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sum_q <= sum_d;
      dec_q <= dec_d;
      upd_q <= upd_d;
    end
  end

endmodule

// File: rtl/cdr_dlf_prog.sv
// Second-order CDR loop filter: decimated votes drive a saturating frequency
// integrator and a freely wrapping phase accumulator for the interpolator.
module cdr_dlf_prog
  import cdr_dlf_pkg::*;
#(
  parameter int CODE_W  = 11,
  parameter int PHASE_W = 16,
  parameter int FREQ_W  = 16,
  parameter int FSHIFT  = 7,
  parameter int DECIM   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  cdr_dlf_prog_if.slave bus
);

  localparam logic signed [FREQ_W-1:0] FREQ_MAX = {1'b0, {(FREQ_W-1){1'b1}}};

  dec_t                     dec_q;
  logic                     upd_q;
  logic [PHASE_W-1:0]       phase_q, phase_d;
  logic signed [FREQ_W-1:0] freq_q, freq_d;
  logic signed [FREQ_W-1:0] freq_shift;
  logic [PHASE_W-1:0]       freq_term;
  logic [PHASE_W-1:0]       kp_ext;
  logic [PHASE_W-1:0]       kp_term;
  longint                   ki_delta;
  longint                   freq_sum;
  logic                     code_valid_q, code_valid_d;
  logic                     freq_sat_q, freq_sat_d;
  logic                     unused_freq_sum_hi;

  dlf_vote_decimator #(
    .DECIM (DECIM)
  ) u_vote (
    .clk   (clk),
    .rst_n (rst_n),
    .up    (bus.up),
    .dn    (bus.dn),
    .dec_q (dec_q),
    .upd_q (upd_q)
  );

  // Gains times a +/-1/0 decision are just select-or-negate; both integrators
  // update from the old freq value, and a frozen update is dropped entirely.
  always_comb begin
    freq_shift = freq_q >>> FSHIFT;
    freq_term  = PHASE_W'(freq_shift);
    kp_ext     = PHASE_W'(bus.kp);

    kp_term  = '0;
    ki_delta = 0;
    if (dec_q == DEC_UP) begin
      kp_term  = kp_ext;
      ki_delta = longint'(bus.ki);
    end else if (dec_q == DEC_DN) begin
      kp_term  = -kp_ext;
      ki_delta = -longint'(bus.ki);
    end
    freq_sum = sat_add(longint'(freq_q), ki_delta, FREQ_W);

    phase_d      = phase_q;
    freq_d       = freq_q;
    code_valid_d = 1'b0;
    if (upd_q && !bus.freeze) begin
      phase_d      = phase_q + freq_term + kp_term;
      freq_d       = freq_sum[FREQ_W-1:0];
      code_valid_d = 1'b1;
    end

    freq_sat_d = (freq_d == FREQ_MAX) || (freq_d == -FREQ_MAX);
  end

  assign unused_freq_sum_hi = &{1'b0, freq_sum[63:FREQ_W]};

  // Integrator and output registers; every output comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q      <= '0;
      freq_q       <= '0;
      code_valid_q <= 1'b0;
      freq_sat_q   <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      freq_q       <= freq_d;
      code_valid_q <= code_valid_d;
      freq_sat_q   <= freq_sat_d;
    end
  end

  assign bus.code       = phase_q[PHASE_W-1 -: CODE_W];
  assign bus.code_valid = code_valid_q;
  assign bus.freq       = freq_q;
  assign bus.freq_sat   = freq_sat_q;

endmodule

// File: tb/tb_cdr_dlf_prog.sv
// Directed bench for cdr_dlf_prog with hand-computed expected values.
module tb_cdr_dlf_prog;

  logic clk;
  logic rst_n;
  int   check_count;
  int   pass_count;

  cdr_dlf_prog_if #(.CODE_W(11), .FREQ_W(16)) bus ();

  cdr_dlf_prog #(
    .CODE_W  (11),
    .PHASE_W (16),
    .FREQ_W  (16),
    .FSHIFT  (7),
    .DECIM   (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drives votes u4[i]/d4[i] for i = from..to, one posedge each; returns at a negedge.
  task automatic applyStimulus(input logic [3:0] u4, input logic [3:0] d4,
                               input int from, input int to);
    for (int i = from; i <= to; i++) begin
      bus.up = u4[i];
      bus.dn = d4[i];
      @(negedge clk);
    end
  endtask

  task automatic doReset();
    rst_n  = 1'b0;
    bus.up = 1'b0;
    bus.dn = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    check_count = 0;
    pass_count  = 0;
    rst_n       = 1'b0;
    bus.up      = 1'b0;
    bus.dn      = 1'b0;
    bus.kp      = 3'd3;
    bus.ki      = 3'd3;
    bus.freeze  = 1'b0;

    // Reset state
    @(negedge clk);
    checkOutput("rst_code", 32'(bus.code), 32'h0);
    checkOutput("rst_freq", 32'($unsigned(bus.freq)), 32'h0);
    checkOutput("rst_cv", 32'(bus.code_valid), 32'h0);
    checkOutput("rst_sat", 32'(bus.freq_sat), 32'h0);

    // Idle: updates with dec 0 still pulse code_valid every 4 cycles
    doReset();
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(4'h0, 4'h0, 0, 0);
      checkOutput($sformatf("idle_cv_%0d", i), 32'(bus.code_valid),
                  ((i >= 5) && (i % 4 == 1)) ? 32'h1 : 32'h0);
    end
    checkOutput("idle_code", 32'(bus.code), 32'h0);
    checkOutput("idle_freq", 32'($unsigned(bus.freq)), 32'h0);

    // Up windows and mixed patterns
    doReset();
    applyStimulus(4'hF, 4'h0, 0, 3);
    applyStimulus(4'hF, 4'h0, 0, 0);
    checkOutput("up1_cv", 32'(bus.code_valid), 32'h1);
    checkOutput("up1_freq", 32'($unsigned(bus.freq)), 32'd3);
    checkOutput("up1_code", 32'(bus.code), 32'h0);
    applyStimulus(4'hF, 4'h0, 1, 1);
    checkOutput("up1_cv_pulse", 32'(bus.code_valid), 32'h0);
    applyStimulus(4'hF, 4'h0, 2, 3);
    // window up,up,dn,none
    applyStimulus(4'b0011, 4'b0100, 0, 0);
    checkOutput("up2_cv", 32'(bus.code_valid), 32'h1);
    checkOutput("up2_freq", 32'($unsigned(bus.freq)), 32'd6);
    applyStimulus(4'b0011, 4'b0100, 1, 3);
    // window up,dn,up,dn
    applyStimulus(4'b0101, 4'b1010, 0, 0);
    checkOutput("mix_up_freq", 32'($unsigned(bus.freq)), 32'd9);
    applyStimulus(4'b0101, 4'b1010, 1, 3);
    // window with up and dn both high
    applyStimulus(4'hF, 4'hF, 0, 0);
    checkOutput("mix_zero_freq", 32'($unsigned(bus.freq)), 32'd9);
    checkOutput("mix_zero_cv", 32'(bus.code_valid), 32'h1);
    applyStimulus(4'hF, 4'hF, 1, 3);
    applyStimulus(4'h0, 4'h0, 0, 0);
    checkOutput("both_freq", 32'($unsigned(bus.freq)), 32'd9);
    checkOutput("both_cv", 32'(bus.code_valid), 32'h1);

    // One dn window from reset wraps phase below zero
    doReset();
    applyStimulus(4'h0, 4'hF, 0, 3);
    applyStimulus(4'h0, 4'h0, 0, 0);
    checkOutput("dn_freq", 32'($unsigned(bus.freq)), 32'hFFFD);
    checkOutput("dn_code", 32'(bus.code), 32'h7FF);
    checkOutput("dn_cv", 32'(bus.code_valid), 32'h1);

    // Saturation with ki = 7: 4681 * 7 = 32767
    bus.ki = 3'd7;
    doReset();
    for (int w = 0; w < 4681; w++) begin
      applyStimulus(4'hF, 4'h0, 0, 3);
    end
    applyStimulus(4'hF, 4'h0, 0, 0);
    checkOutput("sat_freq", 32'($unsigned(bus.freq)), 32'd32767);
    checkOutput("sat_flag", 32'(bus.freq_sat), 32'h1);
    applyStimulus(4'hF, 4'h0, 1, 3);
    applyStimulus(4'h0, 4'hF, 0, 0);
    checkOutput("sat_hold_freq", 32'($unsigned(bus.freq)), 32'd32767);
    checkOutput("sat_hold_flag", 32'(bus.freq_sat), 32'h1);
    applyStimulus(4'h0, 4'hF, 1, 3);
    applyStimulus(4'h0, 4'h0, 0, 0);
    checkOutput("desat_freq", 32'($unsigned(bus.freq)), 32'd32760);
    checkOutput("desat_flag", 32'(bus.freq_sat), 32'h0);

    // Freeze across three up windows, then release
    bus.ki = 3'd3;
    doReset();
    bus.freeze = 1'b1;
    for (int w = 0; w < 3; w++) begin
      applyStimulus(4'hF, 4'h0, 0, 0);
      if (w > 0) begin
        checkOutput($sformatf("frz_cv_%0d", w), 32'(bus.code_valid), 32'h0);
      end
      applyStimulus(4'hF, 4'h0, 1, 3);
    end
    applyStimulus(4'hF, 4'h0, 0, 0);
    checkOutput("frz_cv_3", 32'(bus.code_valid), 32'h0);
    checkOutput("frz_freq", 32'($unsigned(bus.freq)), 32'h0);
    checkOutput("frz_code", 32'(bus.code), 32'h0);
    bus.freeze = 1'b0;
    applyStimulus(4'hF, 4'h0, 1, 3);
    applyStimulus(4'hF, 4'h0, 0, 0);
    checkOutput("unfrz_cv", 32'(bus.code_valid), 32'h1);
    checkOutput("unfrz_freq", 32'($unsigned(bus.freq)), 32'd3);
    applyStimulus(4'hF, 4'h0, 1, 1);

    // Reset asserted with cnt == 2 clears outputs immediately
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_freq", 32'($unsigned(bus.freq)), 32'h0);
    checkOutput("mid_rst_code", 32'(bus.code), 32'h0);
    checkOutput("mid_rst_cv", 32'(bus.code_valid), 32'h0);
    checkOutput("mid_rst_sat", 32'(bus.freq_sat), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'hF, 4'h0, i, i);
      checkOutput($sformatf("post_rst_cv_%0d", i), 32'(bus.code_valid), 32'h0);
    end
    applyStimulus(4'h0, 4'h0, 0, 0);
    checkOutput("post_rst_dec_cv", 32'(bus.code_valid), 32'h1);
    checkOutput("post_rst_dec_freq", 32'($unsigned(bus.freq)), 32'd3);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/cdr_dlf_prog.md
# cdr_dlf_prog

Programmable second-order digital loop filter for the CDR in the PHY receive path. It sits between the bang-bang phase detector (up/dn) and the phase interpolator (code). It decimates phase-detector votes over a configurable window and drives a wrapping phase accumulator from a saturating frequency integrator. Proportional and integral gains are set at runtime, and a freeze input holds loop state.

## Interface
Parameters:
- CODE_W, 11: interpolator code width.
- PHASE_W, 16: phase accumulator width (CODE_W ≤ PHASE_W).
- FREQ_W, 16: signed frequency integrator width.
- FSHIFT, 7: arithmetic right shift applied to freq before it enters the phase path.
- DECIM, 4: votes per decision window (≥1).

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- up, in, 1: phase detector "late".
- dn, in, 1: phase detector "early".
- kp, in, 3: proportional gain, unsigned 0..7.
- ki, in, 3: integral gain, unsigned 0..7.
- freeze, in, 1: hold both integrators.
- code, out, CODE_W: phase[PHASE_W-1 -: CODE_W].
- code_valid, out, 1: one-cycle pulse when phase is written.
- freq, out, FREQ_W: signed frequency integrator value.
- freq_sat, out, 1: high while freq equals +MAX or −MAX.

## Operation
- Per-cycle vote:
  - up&!dn gives +1.
  - dn&!up gives −1.
  - Both or neither gives 0.
- Window counter cnt runs 0..DECIM-1 and wraps. Signed vote sum has width $clog2(DECIM+1)+1.
- On the cycle with cnt==DECIM-1:
  - dec_q <= sign(sum + vote) ∈ {+1, 0, −1}.
  - upd_q <= 1.
  - sum <= 0.
- On the cycle with upd_q==1 and freeze==0, both assignments use the old freq:
  - phase <= phase + (freq >>> FSHIFT) + kp*dec_q, sign-extended to PHASE_W, modulo 2^PHASE_W.
  - freq <= sat(freq + ki*dec_q).
  - code_valid <= 1.
- The update fires with dec_q==0 as well. The phase then advances by the freq term only, and freq is unchanged.
- Saturation:
  - MAX = 2^(FREQ_W-1)−1.
  - Result clamps to [−MAX, +MAX]; −2^(FREQ_W-1) is never produced.
- Phase wraps freely because the interpolator is circular. There is no saturation on phase.
- Freeze:
  - Window counter and voting keep running.
  - Decisions made while freeze is high are discarded: no integrator change and no code_valid.
  - Releasing freeze resumes at the next window boundary.
- kp, ki and freeze are sampled on the update cycle only. Changing them mid-window is legal.

## Timing
- Reset values:
  - cnt=0, sum=0, dec_q=0, upd_q=0.
  - phase=0, freq=0.
  - code=0, code_valid=0, freq_sat=0.
- Latency: the vote on the last window cycle at edge k affects code and freq at edge k+1. code_valid is high for the cycle following edge k+1.
- code_valid rate is at most one pulse per DECIM cycles. With DECIM=1, a pulse can occur every cycle.
- Reset asserted mid-window discards the partial sum. The first window after release is a full DECIM cycles.
- All outputs are registered. There is no combinational path from up, dn, kp or ki to any output.

## Structure
- Package cdr_dlf_pkg holds:
  - typedef dec_t (signed 2-bit).
  - Constants DEC_UP=+1, DEC_DN=−1, DEC_NONE=0.
  - Function sat_add(freq, delta).
- Sub-module dlf_vote_decimator (parameter DECIM) covers voting, the window counter and the sum. It outputs dec_q/upd_q.
- The top level holds the integrators, gain multiply (3-bit × ±1, no multiplier inferred) and output registers.

## Test plan
Defaults for all scenarios: DECIM=4, FSHIFT=7, PHASE_W=FREQ_W=16, CODE_W=11, kp=3, ki=3.
- Reset, then idle for 20 cycles -> code=0, freq=0, code_valid pulses every 4 cycles, phase stays 0.
- up=1 for one window from reset -> code_valid one cycle after the window's last edge, freq=3, phase=3, code=0. A second up window -> freq=6, phase=6.
- Window votes up,up,dn,none -> dec=+1. Window up,dn,up,dn -> dec=0, freq unchanged. up=dn=1 for a whole window -> dec=0.
- dn for one window from reset -> phase=0xFFFD, code=0x7FF, freq=−3 (phase wrap).
- ki=7, up held for 4681 windows -> freq=32767, freq_sat=1. One more up window -> freq stays 32767. Then one dn window -> freq=32760, freq_sat=0.
- freeze=1 across 3 up windows -> no code_valid, freq and phase unchanged. Reset asserted at cnt=2 -> all outputs 0 immediately, and the next decision comes 4 cycles after release.
